wb_port_arbiter: RTL
====================

# wb_port_arbiter

Shares the register file's single write port between the in-order pipeline writeback and a long-latency unit (divider / non-blocking load return). Pipeline writes always win the port. Long-latency results wait in a small FIFO and take idle cycles. If a result waits too long, the block forces a one-cycle pipeline bubble so the result can drain. Sits between the WB stage / long-latency unit and the register-file write port.

## Interface
- DEPTH, 2, long-latency result FIFO entries; power of 2, ≥2
- MAX_WAIT, 4, cycles a FIFO head may wait before a forced bubble; ≥1
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- i_wb_valid  in  1  pipeline WB stage holds a write
- i_wb_rd  in  5  pipeline destination register
- i_wb_data  in  32  pipeline write data
- i_lu_valid  in  1  long-latency result offered
- i_lu_rd  in  5  long-latency destination register
- i_lu_data  in  32  long-latency result
- o_lu_ready  out  1  FIFO can accept; handshake = i_lu_valid & o_lu_ready
- o_rf_wr  out  1  register-file write enable (registered)
- o_rf_rd  out  5  register-file write address (registered)
- o_rf_data  out  32  register-file write data (registered)
- o_stall  out  1  registered; the hazard unit inserts a WB bubble (i_wb_valid=0) in any cycle where this is high
- o_pending_mask  out  32  bit r=1 iff some FIFO entry targets rd r (r≠0); bit 0 always 0
- o_proto_err  out  1  sticky; set when i_wb_valid=1 while o_stall=1

## Operation
- FIFO
  - Circular buffer with read/write pointers and a count.
  - o_lu_ready = (count != DEPTH), derived from registered count only.
  - Push on handshake. Push and pop in the same cycle are both allowed; count is unchanged.
  - No bypass: an entry pushed in cycle N is poppable from N+1.
- Grant, evaluated each cycle N:
  - i_wb_valid=1: grant pipeline. FIFO is not popped.
  - Else, FIFO non-empty: pop the head and grant it.
  - Else: no grant.
- Output register at N+1:
  - o_rf_wr = granted & (rd != 0).
  - o_rf_rd / o_rf_data take the granted values.
  - With no grant: o_rf_wr=0; rd/data hold their previous values.
  - rd=0 results from either source are consumed but never write.
- Age counter (width clog2(MAX_WAIT)+1)
  - Cleared when the FIFO is empty or the head pops.
  - Otherwise increments, saturating at MAX_WAIT.
- FSM
  - NORMAL → FORCE when the FIFO is non-empty, the head is not popped this cycle, and age == MAX_WAIT-1.
  - o_stall=1 exactly while in FORCE.
  - In FORCE the head pops (pipeline bubble guaranteed); FORCE → NORMAL after one cycle.
  - If i_wb_valid=1 in FORCE: pipeline still wins, o_proto_err sets, FSM returns to NORMAL, and age re-arms from 0.
- o_pending_mask is combinational from valid FIFO entries. The issue logic uses it; this block performs no WAW checking.
- Reset
  - Empty FIFO, age=0, FSM=NORMAL.
  - o_rf_wr=0, o_rf_rd=0, o_rf_data=0, o_stall=0, o_proto_err=0, o_pending_mask=0.
  - Reset mid-operation discards queued results.

## Timing
- Pipeline write: i_wb_valid in cycle N → o_rf_wr in N+1. One cycle, always.
- LU write, idle pipeline: handshake in N, pop in N+1, o_rf_wr in N+2.
- Worst-case LU wait with continuous pipeline writes: the head is written ≤ MAX_WAIT+2 cycles after reaching the FIFO head.
- o_lu_ready falls in the cycle after the push that fills the FIFO.
- o_lu_ready rises the cycle after the pop from full.
- o_stall is never high for two consecutive cycles.

## Test plan
- Idle arbitration: after reset, push LU (rd=5, 0xDEADBEEF) with no pipeline traffic → o_lu_ready=1 throughout; o_rf_wr=1, rd=5, data 0xDEADBEEF exactly 2 cycles after the handshake; o_pending_mask[5] high for 1 cycle.
- Priority and starvation: continuous i_wb_valid (rd=1..n), one LU push (rd=7), MAX_WAIT=4 → o_stall high exactly once, 4 cycles after the push lands; pipeline bubble that cycle; rd=7 written the next cycle; o_proto_err stays 0.
- Full/backpressure: DEPTH=2, pipeline busy, three LU offers back-to-back → o_lu_ready=0 after the second push; the third offer is held; it is accepted the cycle after the first pop.
- x0 writes: pipeline rd=0 and LU rd=0 → o_rf_wr stays 0; LU entry is consumed (count returns to 0); o_pending_mask[0]=0.
- Protocol violation: hold i_wb_valid=1 while o_stall=1 → pipeline write occurs; o_proto_err=1 and stays 1 until rst.
- Reset mid-operation: FIFO holding 2 entries, FSM in FORCE, assert rst for 1 cycle → next cycle all outputs are 0, o_lu_ready=1, and no queued result is ever written.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the single register-file write port between the in-order pipeline
// writeback and a long-latency unit. Pipeline writes always win the port.
// Long-latency results queue in a small circular FIFO and use idle cycles.
// A head that has waited too long forces a one-cycle pipeline bubble.

module wb_port_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wb_valid,
    input  logic [4:0]  i_wb_rd,
    input  logic [31:0] i_wb_data,
    input  logic        i_lu_valid,
    input  logic [4:0]  i_lu_rd,
    input  logic [31:0] i_lu_data,
    output logic        o_lu_ready,
    output logic        o_rf_wr,
    output logic [4:0]  o_rf_rd,
    output logic [31:0] o_rf_data,
    output logic        o_stall,
    output logic [31:0] o_pending_mask,
    output logic        o_proto_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int AGE_W = $clog2(MAX_WAIT) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(MAX_WAIT);
    localparam logic [AGE_W-1:0] AGE_TRIP = AGE_W'(MAX_WAIT - 1);

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } state_t;

    logic [4:0]       entryRd_q   [DEPTH];
    logic [31:0]      entryData_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [AGE_W-1:0] age_q, age_d;
    state_t           state_q;
    logic             rfWr_q, rfWr_d;
    logic [4:0]       rfRd_q, rfRd_d;
    logic [31:0]      rfData_q, rfData_d;
    logic             protoErr_q;

    logic             fifoEmpty;
    logic             push;
    logic             pop;
    logic             protoViolation;
    logic             forceTrip;
    logic [PTR_W-1:0] maskIdx;
    logic [31:0]      pendingMask;

    assign fifoEmpty      = (count_q == '0);
    assign o_lu_ready     = (count_q != FULL_CNT);
    assign push           = i_lu_valid & o_lu_ready;
    assign pop            = ~i_wb_valid & ~fifoEmpty;
    assign protoViolation = i_wb_valid & (state_q == FORCE);
    assign forceTrip      = (state_q == NORMAL) & ~fifoEmpty & ~pop & (age_q == AGE_TRIP);

    // Next-state for FIFO pointers, occupancy and the head's wait age.
    always_comb begin
        wrPtr_d = push ? wrPtr_q + PTR_W'(1) : wrPtr_q;
        rdPtr_d = pop  ? rdPtr_q + PTR_W'(1) : rdPtr_q;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        age_d   = age_q;
        if (fifoEmpty || pop || protoViolation) begin
            age_d = '0;
        end else if (age_q != AGE_MAX) begin
            age_d = age_q + AGE_W'(1);
        end
    end

    // Grant selection: pipeline first, otherwise the FIFO head; rd=0 never writes.
    always_comb begin
        rfWr_d   = 1'b0;
        rfRd_d   = rfRd_q;
        rfData_d = rfData_q;
        if (i_wb_valid) begin
            rfWr_d   = (i_wb_rd != 5'd0);
            rfRd_d   = i_wb_rd;
            rfData_d = i_wb_data;
        end else if (pop) begin
            rfWr_d   = (entryRd_q[rdPtr_q] != 5'd0);
            rfRd_d   = entryRd_q[rdPtr_q];
            rfData_d = entryData_q[rdPtr_q];
        end
    end

    // Destination-register mask of every queued result, x0 excluded.
    always_comb begin
        pendingMask = '0;
        maskIdx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CNT_W'(k) < count_q) begin
                maskIdx = rdPtr_q + PTR_W'(k);
                pendingMask[entryRd_q[maskIdx]] = 1'b1;
            end
        end
        pendingMask[0] = 1'b0;
    end

    // FIFO storage; contents are meaningless outside the count window so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            entryRd_q[wrPtr_q]   <= i_lu_rd;
            entryData_q[wrPtr_q] <= i_lu_data;
        end
    end

    // FIFO control, age counter and write-port output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            count_q  <= '0;
            age_q    <= '0;
            rfWr_q   <= 1'b0;
            rfRd_q   <= 5'd0;
            rfData_q <= 32'd0;
        end else begin
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            count_q  <= count_d;
            age_q    <= age_d;
            rfWr_q   <= rfWr_d;
            rfRd_q   <= rfRd_d;
            rfData_q <= rfData_d;
        end
    end

    // Starvation FSM: one FORCE cycle stalls the pipeline, then always back to NORMAL.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= NORMAL;
            protoErr_q <= 1'b0;
        end else begin
            if (protoViolation) begin
                protoErr_q <= 1'b1;
            end
            case (state_q)
                NORMAL:  state_q <= forceTrip ? FORCE : NORMAL;
                FORCE:   state_q <= NORMAL;
                default: state_q <= NORMAL;
            endcase
        end
    end

    assign o_rf_wr        = rfWr_q;
    assign o_rf_rd        = rfRd_q;
    assign o_rf_data      = rfData_q;
    assign o_stall        = (state_q == FORCE);
    assign o_pending_mask = pendingMask;
    assign o_proto_err    = protoErr_q;

endmodule
